// File: rtl/irq_prio_encoder.sv
// irq_prio_encoder: synchronized, edge-captured 8-line active-low priority encoder
// with a frozen valid/ack offer and 74148-style gs_n/eo_n flags.
module irq_prio_encoder #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       ei_n_i,
    input  logic [7:0] req_n_i,
    input  logic       ack_i,
    output logic       valid_o,
    output logic [2:0] code_o,
    output logic [2:0] code_n_o,
    output logic       gs_n_o,
    output logic       eo_n_o,
    output logic [7:0] pending_o
);
    typedef enum logic {IDLE, OFFER} state_t;
    state_t     state_q, state_d;
    logic [7:0] sync_q [SYNC_STAGES];
    logic [7:0] prev_q, pending_q, pending_d, fall, clr;
    logic [2:0] code_q, code_d, hi;
    logic       valid_q, valid_d, gs_n_q, gs_n_d, eo_n_q, eo_n_d;
    always_comb begin
        fall      = prev_q & ~sync_q[SYNC_STAGES-1] & {8{~ei_n_i}};
        clr       = (state_q == OFFER && ack_i) ? 8'b1 << code_q : 8'h00;
        pending_d = (pending_q & ~clr) | fall;
        hi        = 3'd0;
        for (int i = 0; i < 8; i++)
            if (pending_q[i]) hi = 3'(i);
        state_d = state_q;
        valid_d = valid_q;
        code_d  = code_q;
        if (state_q == IDLE && |pending_q) begin
            state_d = OFFER;
            valid_d = 1'b1;
            code_d  = hi;
        end else if (state_q == OFFER && ack_i) begin
            state_d = IDLE;
            valid_d = 1'b0;
        end
        gs_n_d = ~(~ei_n_i & |pending_d);
        eo_n_d = ~(~ei_n_i & ~|pending_d);
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= 8'hFF;
            prev_q    <= 8'hFF;
            pending_q <= 8'h00;
            state_q   <= IDLE;
            valid_q   <= 1'b0;
            code_q    <= 3'd0;
            gs_n_q    <= 1'b1;
            eo_n_q    <= 1'b1;
        end else begin
            sync_q[0] <= req_n_i;
            for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
            prev_q    <= sync_q[SYNC_STAGES-1];
            pending_q <= pending_d;
            state_q   <= state_d;
            valid_q   <= valid_d;
            code_q    <= code_d;
            gs_n_q    <= gs_n_d;
            eo_n_q    <= eo_n_d;
        end
    end
    assign valid_o   = valid_q;
    assign code_o    = code_q;
    assign code_n_o  = ~code_q;
    assign gs_n_o    = gs_n_q;
    assign eo_n_o    = eo_n_q;
    assign pending_o = pending_q;
endmodule

// File: tb/tb_irq_prio_encoder.sv
// tb_irq_prio_encoder: table-driven per-edge vectors plus hand sequences for
// the ack/capture collision and reset during an offer.
module tb_irq_prio_encoder;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ei_n = 1'b0;
    logic [7:0] req_n = 8'hFF;
    logic       ack = 1'b0;
    logic       valid, gs_n, eo_n;
    logic [2:0] code, code_n;
    logic [7:0] pend;
    int         n_chk = 0;
    int         n_fail = 0;

    typedef struct {
        logic       rst;
        logic       ei_n;
        logic [7:0] req_n;
        logic       ack;
        logic       v;
        logic [2:0] c;
        logic       gs;
        logic       eo;
        logic [7:0] p;
    } vec_t;
    vec_t vecs[$];

    irq_prio_encoder #(.SYNC_STAGES(2)) dut (
        .clk_i(clk), .rst_i(rst), .ei_n_i(ei_n), .req_n_i(req_n), .ack_i(ack),
        .valid_o(valid), .code_o(code), .code_n_o(code_n),
        .gs_n_o(gs_n), .eo_n_o(eo_n), .pending_o(pend)
    );

    always #5 clk = ~clk;

    task automatic add(input logic r, input logic e, input logic [7:0] q, input logic a,
                       input logic v, input logic [2:0] c, input logic gs,
                       input logic eo, input logic [7:0] p, input int n = 1);
        vec_t t;
        t = '{r, e, q, a, v, c, gs, eo, p};
        for (int i = 0; i < n; i++) vecs.push_back(t);
    endtask

    task automatic step(input logic r, input logic e, input logic [7:0] q, input logic a);
        rst = r; ei_n = e; req_n = q; ack = a;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic v, input logic [2:0] c,
                       input logic gs, input logic eo, input logic [7:0] p);
        n_chk++;
        if ({valid, code, gs_n, eo_n, pend} !== {v, c, gs, eo, p}) begin
            n_fail++;
            $display("FAIL %s: got valid=%0b code=%0d gs_n=%0b eo_n=%0b pending=%h, expected valid=%0b code=%0d gs_n=%0b eo_n=%0b pending=%h",
                     name, valid, code, gs_n, eo_n, pend, v, c, gs, eo, p);
        end
        n_chk++;
        if (code_n !== ~c) begin
            n_fail++;
            $display("FAIL %s code_n: got %b, expected %b", name, code_n, ~c);
        end
    endtask

    initial begin
        // reset, then bit 5 held low with a single ack
        add(1,0,8'hFF,0, 0,0,1,1,8'h00, 2);
        add(0,0,8'hFF,0, 0,0,1,0,8'h00);
        add(0,0,8'hDF,0, 0,0,1,0,8'h00, 2);
        add(0,0,8'hDF,0, 0,0,0,1,8'h20);
        add(0,0,8'hDF,0, 1,5,0,1,8'h20, 2);
        add(0,0,8'hDF,1, 0,5,1,0,8'h00);
        add(0,0,8'hDF,0, 0,5,1,0,8'h00, 20);
        add(0,0,8'hFF,0, 0,5,1,0,8'h00, 3);
        // bits 6 and 2 together, ack held high
        add(0,0,8'hBB,1, 0,5,1,0,8'h00, 2);
        add(0,0,8'hBB,1, 0,5,0,1,8'h44);
        add(0,0,8'hBB,1, 1,6,0,1,8'h44);
        add(0,0,8'hBB,1, 0,6,0,1,8'h04);
        add(0,0,8'hBB,1, 1,2,0,1,8'h04);
        add(0,0,8'hBB,1, 0,2,1,0,8'h00, 2);
        add(0,0,8'hFF,0, 0,2,1,0,8'h00, 3);
        // bit 1 offered, bit 7 arrives without preempting
        add(0,0,8'hFD,0, 0,2,1,0,8'h00, 2);
        add(0,0,8'hFD,0, 0,2,0,1,8'h02);
        add(0,0,8'hFD,0, 1,1,0,1,8'h02);
        add(0,0,8'h7D,0, 1,1,0,1,8'h02, 2);
        add(0,0,8'h7D,0, 1,1,0,1,8'h82, 2);
        add(0,0,8'h7D,1, 0,1,0,1,8'h80);
        add(0,0,8'h7D,0, 1,7,0,1,8'h80);
        add(0,0,8'h7D,1, 0,7,1,0,8'h00);
        add(0,0,8'h7D,0, 0,7,1,0,8'h00);
        add(0,0,8'hFF,0, 0,7,1,0,8'h00, 3);
        // disabled: bit 3 fall discarded; then offer of 4 survives ei_n going high
        add(0,1,8'hF7,0, 0,7,1,1,8'h00, 4);
        add(0,1,8'hFF,0, 0,7,1,1,8'h00, 3);
        add(0,0,8'hEF,0, 0,7,1,0,8'h00, 2);
        add(0,0,8'hEF,0, 0,7,0,1,8'h10);
        add(0,0,8'hEF,0, 1,4,0,1,8'h10);
        add(0,1,8'hEF,0, 1,4,1,1,8'h10, 2);
        add(0,1,8'hEF,1, 0,4,1,1,8'h00);
        add(0,0,8'hEF,0, 0,4,1,0,8'h00);
        add(0,0,8'hFF,0, 0,4,1,0,8'h00, 3);

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].ei_n, vecs[i].req_n, vecs[i].ack);
            chk($sformatf("vec[%0d]", i), vecs[i].v, vecs[i].c, vecs[i].gs, vecs[i].eo, vecs[i].p);
        end

        // ack of code 0 on the same edge a new bit-0 fall is captured
        step(0,0,8'hFE,0); step(0,0,8'hFE,0);
        step(0,0,8'hFE,0); chk("b0_capture", 0,4,0,1,8'h01);
        step(0,0,8'hFE,0); chk("b0_offer", 1,0,0,1,8'h01);
        step(0,0,8'hFF,0); step(0,0,8'hFF,0); step(0,0,8'hFF,0);
        step(0,0,8'hFE,0); step(0,0,8'hFE,0);
        chk("b0_waiting", 1,0,0,1,8'h01);
        step(0,0,8'hFE,1); chk("set_wins", 0,0,0,1,8'h01);
        step(0,0,8'hFE,0); chk("reoffer", 1,0,0,1,8'h01);

        // reset mid-offer, line still low through reset is captured once
        step(1,0,8'hFE,0); chk("rst_offer", 0,0,1,1,8'h00);
        step(0,0,8'hFE,0); chk("post_rst1", 0,0,1,0,8'h00);
        step(0,0,8'hFE,0); chk("post_rst2", 0,0,1,0,8'h00);
        step(0,0,8'hFE,0); chk("post_rst_cap", 0,0,0,1,8'h01);
        step(0,0,8'hFE,0); chk("post_rst_offer", 1,0,0,1,8'h01);
        step(0,0,8'hFE,1); chk("post_rst_ack", 0,0,1,0,8'h00);
        step(0,0,8'hFE,0); chk("no_recapture", 0,0,1,0,8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
